// File: rtl/fifo_word_reader.sv
// Read-side consumer of the serial async FIFO: pulls bits, assembles words, hands them out on valid/ready.
// Optional macro WORD_READER_PARITY_EN appends an even-parity bit per word and adds o_Parity_Err.
module fifo_word_reader #(
   parameter int WORD_WIDTH = 8,
   parameter bit LSB_FIRST  = 1'b1
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   input  logic                  i_Empty,
   output logic                  o_R_en,
   input  logic                  i_Data_In,
   output logic [WORD_WIDTH-1:0] o_Word,
   output logic                  o_Valid,
   input  logic                  i_Ready,
   output logic                  o_Busy
`ifdef WORD_READER_PARITY_EN
   ,
   output logic                  o_Parity_Err
`endif
);

`ifdef WORD_READER_PARITY_EN
   localparam int NB = WORD_WIDTH + 1;
`else
   localparam int NB = WORD_WIDTH;
`endif
   localparam int CW = $clog2(NB + 1);

   typedef enum logic {
      FILL     = 1'b0,
      WAIT_OUT = 1'b1
   } state_t;

   state_t                state;
   logic [CW-1:0]         req_cnt;
   logic [CW-1:0]         rcv_cnt;
   logic                  rd_pend;
   logic [WORD_WIDTH-1:0] shift_q;
   logic [WORD_WIDTH-1:0] word_next;
   logic                  final_cap;
   logic                  out_free;
   logic                  issue_ok;
`ifdef WORD_READER_PARITY_EN
   logic                  park_err_q;
   logic                  err_next;
`endif

   assign final_cap = rd_pend && (rcv_cnt == CW'(NB - 1));
   assign out_free  = !o_Valid || i_Ready;

   // The first read of the next word may overlap the final capture of the current one.
   assign issue_ok  = (req_cnt < CW'(NB)) ||
                      ((req_cnt == CW'(NB)) && final_cap && out_free);
   assign o_R_en    = !i_Rst && (state == FILL) && !i_Empty && issue_ok;

   assign o_Busy    = (state == WAIT_OUT) || (req_cnt != '0) || (rcv_cnt != '0);

   // Merge the bit arriving this cycle so a completed word can be loaded without an extra cycle.
   always_comb begin
      word_next = shift_q;
      for (int i = 0; i < WORD_WIDTH; i++) begin
         if (rd_pend && (rcv_cnt == CW'(LSB_FIRST ? i : (WORD_WIDTH - 1 - i)))) begin
            word_next[i] = i_Data_In;
         end
      end
   end

`ifdef WORD_READER_PARITY_EN
   assign err_next = (^word_next) ^ i_Data_In;
`endif

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state   <= FILL;
         req_cnt <= '0;
         rcv_cnt <= '0;
         rd_pend <= 1'b0;
         shift_q <= '0;
         o_Word  <= '0;
         o_Valid <= 1'b0;
`ifdef WORD_READER_PARITY_EN
         park_err_q   <= 1'b0;
         o_Parity_Err <= 1'b0;
`endif
      end else begin
         rd_pend <= o_R_en;
         if (rd_pend) begin
            shift_q <= word_next;
         end
         case (state)
            FILL: begin
               if (final_cap) begin
                  if (out_free) begin
                     o_Word  <= word_next;
                     o_Valid <= 1'b1;
                     rcv_cnt <= '0;
                     req_cnt <= o_R_en ? CW'(1) : '0;
`ifdef WORD_READER_PARITY_EN
                     o_Parity_Err <= err_next;
`endif
                  end else begin
                     // Output still occupied: park the finished word and stop reading.
                     state   <= WAIT_OUT;
                     rcv_cnt <= rcv_cnt + CW'(1);
`ifdef WORD_READER_PARITY_EN
                     park_err_q <= err_next;
`endif
                  end
               end else begin
                  if (rd_pend) begin
                     rcv_cnt <= rcv_cnt + CW'(1);
                  end
                  if (o_R_en) begin
                     req_cnt <= req_cnt + CW'(1);
                  end
                  if (o_Valid && i_Ready) begin
                     o_Valid <= 1'b0;
                  end
               end
            end
            WAIT_OUT: begin
               if (i_Ready) begin
                  o_Word  <= shift_q;
                  o_Valid <= 1'b1;
                  rcv_cnt <= '0;
                  req_cnt <= '0;
                  state   <= FILL;
`ifdef WORD_READER_PARITY_EN
                  o_Parity_Err <= park_err_q;
`endif
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_word_reader.sv
// Directed bench for fifo_word_reader: LSB-first and MSB-first instances fed from one FIFO model.
// Under WORD_READER_PARITY_EN each pushed word carries an even-parity bit and parity errors are checked.
module tb_fifo_word_reader;

`ifdef WORD_READER_PARITY_EN
   localparam int NB_T = 9;
`else
   localparam int NB_T = 8;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       stall = 1'b0;
   logic       ready = 1'b0;
   logic       empty;
   logic       data_in = 1'b0;
   logic       r_en, r_en_msb;
   logic       valid, valid_msb;
   logic       busy, busy_msb;
   logic [7:0] word, word_msb;
`ifdef WORD_READER_PARITY_EN
   logic       perr, perr_msb;
`endif

   logic       fifo_mem [0:255];
   int         wr_cnt = 0;
   int         rd_ptr = 0;
   int         vectors = 0;
   int         miscompares = 0;

   logic [7:0] exp_lsb [4];
   logic [7:0] exp_msb [4];

   always #5 clk = ~clk;

   assign empty = stall || (rd_ptr >= wr_cnt);

   // FIFO read port: data appears the cycle after the read enable.
   always @(posedge clk) begin
      if (r_en) begin
         data_in <= fifo_mem[rd_ptr];
         rd_ptr  <= rd_ptr + 1;
      end
   end

   fifo_word_reader #(.WORD_WIDTH(8), .LSB_FIRST(1'b1)) dut (
      .i_Clk(clk), .i_Rst(rst), .i_Empty(empty), .o_R_en(r_en), .i_Data_In(data_in),
      .o_Word(word), .o_Valid(valid), .i_Ready(ready), .o_Busy(busy)
`ifdef WORD_READER_PARITY_EN
      , .o_Parity_Err(perr)
`endif
   );

   fifo_word_reader #(.WORD_WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
      .i_Clk(clk), .i_Rst(rst), .i_Empty(empty), .o_R_en(r_en_msb), .i_Data_In(data_in),
      .o_Word(word_msb), .o_Valid(valid_msb), .i_Ready(ready), .o_Busy(busy_msb)
`ifdef WORD_READER_PARITY_EN
      , .o_Parity_Err(perr_msb)
`endif
   );

   task automatic push_bit(input logic b);
      fifo_mem[wr_cnt] = b;
      wr_cnt++;
   endtask

   task automatic push_word(input logic [7:0] w);
      for (int i = 0; i < 8; i++) push_bit(w[i]);
`ifdef WORD_READER_PARITY_EN
      push_bit(^w);
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1; ready = 1'b1; stall = 1'b0;
      push_word(8'h4D);
      @(negedge clk); #1;
      vectors++; if (r_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_r_en got %b want 0", r_en); end
      vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b want 0", valid); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
      vectors++; if (word !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_word got %h want 00", word); end
`ifdef WORD_READER_PARITY_EN
      vectors++; if (perr !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_perr got %b want 0", perr); end
`endif
   endtask

   task automatic test_basic();
      logic ev;
      @(negedge clk); rst = 1'b0;
      for (int k = 0; k <= NB_T + 2; k++) begin
         #1;
         vectors++; if (r_en !== (k < NB_T)) begin miscompares++; $display("[TB] FAIL basic_r_en cyc %0d got %b want %b", k, r_en, k < NB_T); end
         ev = (k == NB_T + 1);
         vectors++; if (valid !== ev) begin miscompares++; $display("[TB] FAIL basic_valid cyc %0d got %b want %b", k, valid, ev); end
         if (ev) begin
            vectors++; if (word !== 8'h4D) begin miscompares++; $display("[TB] FAIL basic_word got %h want 4D", word); end
            vectors++; if (word_msb !== 8'hB2) begin miscompares++; $display("[TB] FAIL basic_word_msb got %h want B2", word_msb); end
`ifdef WORD_READER_PARITY_EN
            vectors++; if (perr !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_perr got %b want 0", perr); end
`endif
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      rst = 1'b1; ready = 1'b0;
      push_word(8'h4D); push_word(8'h1E);
      @(negedge clk); @(negedge clk); rst = 1'b0;
      for (int k = 0; k <= 2 * NB_T + 3; k++) begin
         #1;
         vectors++; if (r_en !== (k < 2 * NB_T)) begin miscompares++; $display("[TB] FAIL bp_r_en cyc %0d got %b want %b", k, r_en, k < 2 * NB_T); end
         vectors++; if (valid !== (k >= NB_T + 1)) begin miscompares++; $display("[TB] FAIL bp_valid cyc %0d got %b want %b", k, valid, k >= NB_T + 1); end
         if (k >= NB_T + 1) begin
            vectors++; if (word !== 8'h4D) begin miscompares++; $display("[TB] FAIL bp_word1_stable cyc %0d got %h want 4D", k, word); end
         end
         if (k == 2 * NB_T + 2) begin
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_busy_parked got %b want 1", busy); end
         end
         @(negedge clk);
      end
      ready = 1'b1;
      @(negedge clk); ready = 1'b0; #1;
      vectors++; if (valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_valid_after got %b want 1", valid); end
      vectors++; if (word !== 8'h1E) begin miscompares++; $display("[TB] FAIL bp_word2 got %h want 1E", word); end
      vectors++; if (word_msb !== 8'h78) begin miscompares++; $display("[TB] FAIL bp_word2_msb got %h want 78", word_msb); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_busy_after got %b want 0", busy); end
      @(negedge clk); #1;
      vectors++; if (word !== 8'h1E || valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_word2_hold got %h/%b want 1E/1", word, valid); end
      ready = 1'b1;
      @(negedge clk); #1;
      vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_drain_valid got %b want 0", valid); end
   endtask

   task automatic test_empty_stall();
      logic er, ev;
      rst = 1'b1; ready = 1'b1; stall = 1'b0;
      push_word(8'hC6);
      @(negedge clk); @(negedge clk); rst = 1'b0;
      for (int k = 0; k <= NB_T + 7; k++) begin
         stall = (k >= 3 && k < 8);
         #1;
         er = (k < 3) || (k >= 8 && k < NB_T + 5);
         ev = (k == NB_T + 6);
         vectors++; if (r_en !== er) begin miscompares++; $display("[TB] FAIL stall_r_en cyc %0d got %b want %b", k, r_en, er); end
         vectors++; if (valid !== ev) begin miscompares++; $display("[TB] FAIL stall_valid cyc %0d got %b want %b", k, valid, ev); end
         if (stall) begin
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_busy cyc %0d got %b want 1", k, busy); end
         end
         if (ev) begin
            vectors++; if (word !== 8'hC6) begin miscompares++; $display("[TB] FAIL stall_word got %h want C6", word); end
            vectors++; if (word_msb !== 8'h63) begin miscompares++; $display("[TB] FAIL stall_word_msb got %h want 63", word_msb); end
         end
         @(negedge clk);
      end
      stall = 1'b0;
   endtask

   task automatic test_reset_mid_word();
      rst = 1'b1; ready = 1'b1;
      push_word(8'hFF);
      push_bit(1'b1); push_bit(1'b1); push_bit(1'b1);
      @(negedge clk); @(negedge clk); rst = 1'b0;
      for (int k = 0; k <= NB_T + 2; k++) begin
         #1;
         if (k == NB_T + 1) begin
            vectors++; if (valid !== 1'b1 || word !== 8'hFF) begin miscompares++; $display("[TB] FAIL mid_pre_word got %h/%b want FF/1", word, valid); end
         end
         @(negedge clk);
      end
      rst = 1'b1;
      push_word(8'h2B);
      #1;
      vectors++; if (r_en !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_r_en got %b want 0", r_en); end
      vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_valid got %b want 0", valid); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_busy got %b want 0", busy); end
      vectors++; if (word !== 8'h00) begin miscompares++; $display("[TB] FAIL mid_rst_word got %h want 00", word); end
      @(negedge clk); @(negedge clk); rst = 1'b0;
      for (int k = 0; k <= NB_T + 1; k++) begin
         #1;
         vectors++; if (r_en !== (k < NB_T)) begin miscompares++; $display("[TB] FAIL mid_post_r_en cyc %0d got %b want %b", k, r_en, k < NB_T); end
         if (k == NB_T + 1) begin
            vectors++; if (valid !== 1'b1 || word !== 8'h2B) begin miscompares++; $display("[TB] FAIL mid_post_word got %h/%b want 2B/1", word, valid); end
            vectors++; if (word_msb !== 8'hD4) begin miscompares++; $display("[TB] FAIL mid_post_word_msb got %h want D4", word_msb); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic ev;
      int   idx;
      rst = 1'b1; ready = 1'b1;
      for (int i = 0; i < 4; i++) push_word(exp_lsb[i]);
      @(negedge clk); @(negedge clk); rst = 1'b0;
      for (int k = 0; k <= 4 * NB_T + 2; k++) begin
         #1;
         ev  = (k >= NB_T + 1) && (((k - 1) % NB_T) == 0) && (k <= 4 * NB_T + 1);
         idx = (k - 1) / NB_T - 1;
         vectors++; if (r_en !== (k < 4 * NB_T)) begin miscompares++; $display("[TB] FAIL b2b_r_en cyc %0d got %b want %b", k, r_en, k < 4 * NB_T); end
         vectors++; if (valid !== ev) begin miscompares++; $display("[TB] FAIL b2b_valid cyc %0d got %b want %b", k, valid, ev); end
         if (ev) begin
            vectors++; if (word !== exp_lsb[idx]) begin miscompares++; $display("[TB] FAIL b2b_word%0d got %h want %h", idx, word, exp_lsb[idx]); end
            vectors++; if (word_msb !== exp_msb[idx]) begin miscompares++; $display("[TB] FAIL b2b_word_msb%0d got %h want %h", idx, word_msb, exp_msb[idx]); end
         end
         @(negedge clk);
      end
   endtask

`ifdef WORD_READER_PARITY_EN
   task automatic test_parity();
      logic [7:0] w;
      rst = 1'b1; ready = 1'b1;
      w = 8'h4D;
      for (int i = 0; i < 8; i++) push_bit(w[i]);
      push_bit(1'b0);
      for (int i = 0; i < 8; i++) push_bit(w[i]);
      push_bit(1'b1);
      @(negedge clk); @(negedge clk); rst = 1'b0;
      for (int k = 0; k <= 2 * NB_T + 2; k++) begin
         #1;
         if (k == NB_T + 1) begin
            vectors++; if (valid !== 1'b1 || word !== 8'h4D) begin miscompares++; $display("[TB] FAIL par_word_good got %h/%b want 4D/1", word, valid); end
            vectors++; if (perr !== 1'b0) begin miscompares++; $display("[TB] FAIL par_err_good got %b want 0", perr); end
         end
         if (k == 2 * NB_T + 1) begin
            vectors++; if (valid !== 1'b1 || word !== 8'h4D) begin miscompares++; $display("[TB] FAIL par_word_bad got %h/%b want 4D/1", word, valid); end
            vectors++; if (perr !== 1'b1) begin miscompares++; $display("[TB] FAIL par_err_bad got %b want 1", perr); end
         end
         @(negedge clk);
      end
   endtask
`endif

   initial begin
      exp_lsb[0] = 8'h4D; exp_lsb[1] = 8'h1E; exp_lsb[2] = 8'hC6; exp_lsb[3] = 8'h2B;
      exp_msb[0] = 8'hB2; exp_msb[1] = 8'h78; exp_msb[2] = 8'h63; exp_msb[3] = 8'hD4;
      test_reset();
      test_basic();
      test_backpressure();
      test_empty_stall();
      test_reset_mid_word();
      test_back_to_back();
`ifdef WORD_READER_PARITY_EN
      test_parity();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
